// File: rtl/wishbone_stream_master_if.sv
// wishbone_stream_master_if: request/response streams plus the Wishbone initiator bus
interface wishbone_stream_master_if;
  logic req_val, req_rdy;
  logic [68:0] req_msg;
  logic resp_val, resp_rdy;
  logic [32:0] resp_msg;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0] wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic wbm_ack_i;
  logic [31:0] wbm_dat_i;
  modport master(
    input req_val, req_msg, resp_rdy, wbm_ack_i, wbm_dat_i,
    output req_rdy, resp_val, resp_msg, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
  modport slave(
    output req_val, req_msg, resp_rdy, wbm_ack_i, wbm_dat_i,
    input req_rdy, resp_val, resp_msg, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wishbone_stream_master.sv
// wishbone_stream_master: one classic Wishbone cycle per stream request, ack data or timeout returned as a response
module wishbone_stream_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RESP_ON_WRITE = 1'b1
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wishbone_stream_master_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic expire;
  assign bus.req_rdy = state == IDLE && !wb_rst_i;
  assign bus.resp_val = state == RESP;
  assign expire = TIMEOUT_CYCLES != 0 && cnt == LAST;
  // ack takes priority over a timeout expiring in the same cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      bus.resp_msg <= '0;
      {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_dat_o, bus.wbm_adr_o} <= '0;
    end else if (state == IDLE) begin
      if (bus.req_val) begin
        {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_dat_o, bus.wbm_adr_o} <= {2'b11, bus.req_msg};
        cnt <= '0;
        state <= BUS;
      end
    end else if (state == BUS) begin
      if (bus.wbm_ack_i || expire) begin
        {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_dat_o, bus.wbm_adr_o} <= '0;
        bus.resp_msg <= {!bus.wbm_ack_i, bus.wbm_ack_i && !bus.wbm_we_o ? bus.wbm_dat_i : 32'h0};
        state <= bus.wbm_ack_i && bus.wbm_we_o && !RESP_ON_WRITE ? IDLE : RESP;
      end else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end else if (bus.resp_rdy)
      state <= IDLE;
endmodule
